// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants made while fetch is waiting.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count holds once it reaches the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// One-outstanding arbiter sharing the core memory port between fetch and data,
// with data priority, fetch anti-starvation and flush-safe draining.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rdata_valid,
    input  logic                d_en,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rdata_valid,
    output logic                d_write_finish,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e state_q, state_d;

    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   wdata_q;

    logic grant;
    logic grant_inst;
    logic done;
    logic at_limit;

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_inst = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && (i_en || d_en)) begin
                    grant      = 1'b1;
                    grant_inst = i_en && (!d_en || at_limit);
                    state_d    = REQ;
                end
            end
            REQ: begin
                // An accepted request always gets a response, so a flush
                // racing the handshake must still drain it.
                if (mem_req_ready) begin
                    state_d = flush ? DRAIN : RESP;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    done    = !flush;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is captured at grant so requester changes afterwards are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_INST;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= grant_inst ? OWN_INST : OWN_DATA;
            we_q    <= grant_inst ? 1'b0 : d_we;
            addr_q  <= grant_inst ? i_addr : d_addr;
            wmask_q <= grant_inst ? '0 : d_wmask;
            wdata_q <= grant_inst ? '0 : d_wdata;
        end
    end

    mem_arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (grant && !grant_inst && i_en),
        .clr_i     (flush || (grant && grant_inst)),
        .at_limit_o(at_limit)
    );

    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wmask = wmask_q;
    assign mem_wdata = wdata_q;

    assign i_rdata        = mem_rdata;
    assign d_rdata        = mem_rdata;
    assign i_rdata_valid  = done && (owner_q == OWN_INST);
    assign d_rdata_valid  = done && (owner_q == OWN_DATA) && !we_q;
    assign d_write_finish = done && (owner_q == OWN_DATA) && we_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single core-side memory port between the instruction-fetch requester (IF) and the data requester (MEM stage load/store/cacop path). The block is a one-outstanding-transaction arbiter with fixed data priority, an anti-starvation override for fetch, and flush-safe draining of in-flight accesses. It sits between the pipeline stages and the cache/AXI bridge. Both requester ports use the pipeline's level-held `en`/`we`/`addr`/`wmask`/`wdata` convention with `rdata_valid`/`write_finish` pulses.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `wmask` is `DATA_W/8` bits.
- `STARVE_LIMIT`, 4: consecutive data grants made while fetch waits before fetch is forced to win; range 1..7.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: excp/ertn/branch flush; kills pending and in-flight requests.
- `i_en` in 1: fetch request, held until `i_rdata_valid`.
- `i_addr` in ADDR_W: fetch address.
- `i_rdata` out DATA_W: fetch read data.
- `i_rdata_valid` out 1: one-cycle pulse when fetch data is returned.
- `d_en` in 1: data request, held until its done pulse.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wmask` in DATA_W/8: byte mask.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data.
- `d_rdata_valid` out 1: load done pulse.
- `d_write_finish` out 1: store done pulse.
- `mem_req` out 1: downstream request valid.
- `mem_we` out 1: downstream write.
- `mem_addr` out ADDR_W: downstream address.
- `mem_wmask` out DATA_W/8: downstream mask.
- `mem_wdata` out DATA_W: downstream write data.
- `mem_req_ready` in 1: downstream accepts when `mem_req & mem_req_ready`.
- `mem_resp_valid` in 1: response for the accepted request; arrives at least one cycle after acceptance.
- `mem_rdata` in DATA_W: response data.

## Operation
- States: IDLE, REQ (request presented, not yet accepted), RESP (accepted, awaiting response), DRAIN (accepted, response to be discarded).
- IDLE:
  - If `flush` is high, no grant is made.
  - Otherwise, with any `en` high, pick a winner: data wins unless `i_en & starve_cnt == STARVE_LIMIT`, in which case fetch wins.
  - Latch owner, we (forced 0 for fetch), addr, wmask, wdata into registers, then go to REQ.
- REQ:
  - `mem_req` = 1, driven from the latched registers.
  - On handshake, go to RESP.
  - If `flush` is high and there is no handshake that cycle, go to IDLE; the request is dropped.
  - If `flush` and handshake coincide, go to DRAIN.
- RESP:
  - On `mem_resp_valid`, pulse the owner's done output combinationally in the same cycle, then go to IDLE.
  - Done outputs: `i_rdata_valid` for fetch; `d_rdata_valid` when `we=0`, `d_write_finish` when `we=1`.
  - If `flush` is high without `mem_resp_valid`, go to DRAIN.
  - If `flush` and `mem_resp_valid` coincide, suppress the pulse and go to IDLE.
- DRAIN: wait for `mem_resp_valid`, produce no pulse, then go to IDLE.
- Data outputs: `i_rdata` = `d_rdata` = `mem_rdata` (pass-through); they are meaningful only alongside a pulse.
- `starve_cnt` (3 bits):
  - +1 at every data grant made while `i_en` is high, saturating at STARVE_LIMIT.
  - Cleared on every fetch grant.
  - Cleared on `flush`.
- Requests whose `en` drops before being granted are forgotten. The latched copy is used once granted; requester changes after the grant are ignored.

## Timing
- Reset values:
  - State IDLE, `starve_cnt` 0.
  - All `mem_*` outputs 0 and all pulses 0.
  - Latched registers 0.
- Minimum latency with ready and response immediate: `en` seen in cycle N, `mem_req` in N+1 (accepted), `mem_resp_valid` plus done pulse in N+2. A new grant can be made in N+3 at the earliest.
- Done pulses are exactly one cycle wide and never occur outside RESP.
- `mem_req` stays stable (addr/we/wmask/wdata unchanged) until handshake or flush.
- Reset asserted mid-transaction returns to IDLE immediately; the downstream must be reset together with this block.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (IDLE/REQ/RESP/DRAIN).
  - Owner constants OWN_INST=0, OWN_DATA=1.
  - Starve-counter width.
  - The package is imported alongside `defines.sv`.
- One natural sub-module: `mem_arb_starve_cnt`, a saturating counter with inc/clear and an `at_limit` output. Everything else stays in `mem_port_arbiter`.

## Test plan
- Load only: `d_en=1, d_we=0, d_addr=0x1000`, ready and response immediate, `mem_rdata=0xDEADBEEF` -> `mem_req` in cycle 1 with `mem_addr=0x1000`; `d_rdata_valid=1, d_rdata=0xDEADBEEF` in cycle 2; `i_rdata_valid` stays 0.
- Contention: `i_en` and `d_en` held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; fetch never waits more than 4 data grants.
- Store backpressure: `d_we=1, d_wmask=0b0011, d_wdata=0x1234`, `mem_req_ready` low for 5 cycles -> `mem_req`/`mem_addr`/`mem_wdata` stable for all 5 cycles; one `d_write_finish` pulse after the response.
- Flush in REQ: flush while `mem_req=1` and ready=0 -> `mem_req=0` next cycle, state IDLE, no done pulse, `starve_cnt`=0.
- Flush in RESP: flush one cycle after acceptance, response 3 cycles later with `mem_rdata=0xAAAA5555` -> no pulse on any port; a new `i_en` is granted only after the response has been drained.
- Async reset: assert `reset=0` during RESP -> all outputs 0 within the same cycle; after release, a fresh `d_en` completes normally.
